// File: rtl/div_issue_ctrl_pkg.sv
// Shared divide-issue definitions: onehot divide opcodes (also used by the decoder),
// the issue FSM state type and the divide-by-zero bypass result helper.
package div_issue_ctrl_pkg;

  localparam logic [3:0] DIV_OP_DIV_W  = 4'b0001;
  localparam logic [3:0] DIV_OP_DIV_WU = 4'b0010;
  localparam logic [3:0] DIV_OP_MOD_W  = 4'b0100;
  localparam logic [3:0] DIV_OP_MOD_WU = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_BUSY  = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } div_state_e;

  // Quotient of x/0 is all ones; remainder of x/0 is the dividend.
  function automatic logic [31:0] div_zero_result(input logic [3:0] op, input logic [31:0] src1);
    return ((op & (DIV_OP_DIV_W | DIV_OP_DIV_WU)) != 4'b0000) ? '1 : src1;
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/hand-back controller sitting between the EX stage and an external multi-cycle divider.
// Optional macro DIV_ZERO_BYPASS_EN: divide-by-zero completes without using the divider.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        div_op,
  output logic [DATA_W-1:0] div_src1,
  output logic [DATA_W-1:0] div_src2,
  input  logic [DATA_W-1:0] div_res,
  input  logic              div_done
);

  div_state_e        state;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] res_q;
  logic              accept;

  assign req_ready = resetn & (state == ST_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      src1_q <= '0;
      src2_q <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
`ifdef DIV_ZERO_BYPASS_EN
            if (req_src2 == '0) begin
              res_q <= div_zero_result(req_op, req_src1);
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
`else
            state <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          // A flush that coincides with completion simply drops the result.
          if (div_done) begin
            if (flush) begin
              state <= ST_IDLE;
            end else begin
              res_q <= div_res;
              state <= ST_DONE;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The divider cannot be aborted; keep it fed until it reports done.
          if (div_done) state <= ST_IDLE;
        end
        ST_DONE: begin
          if (flush || rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign div_op    = ((state == ST_BUSY) || (state == ST_DRAIN)) ? op_q : 4'b0000;
  assign div_src1  = src1_q;
  assign div_src2  = src2_q;
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = res_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl; the bench acts as the divider itself.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  div_op;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic [31:0] div_res;
  logic        div_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .div_op(div_op), .div_src1(div_src1), .div_src2(div_src2),
    .div_res(div_res), .div_done(div_done)
  );

  // Divider result model: computes from what the DUT presents to the divider.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (op[0] | op[1]) ? 32'hFFFF_FFFF : a;
    case (op)
      4'b0001: return 32'(sa / sb);
      4'b0010: return a / b;
      4'b0100: return 32'(sa % sb);
      4'b1000: return a % b;
      default: return 32'd0;
    endcase
  endfunction

  assign div_res = model(div_op, div_src1, div_src2);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({req_ready, rsp_valid, div_op} !== 6'b0 || rsp_data !== 32'd0 || {div_src1, div_src2} !== 64'd0) begin
      n_fail++; $display("FAIL reset_outputs: rdy=%b vld=%b op=%b data=%h s1=%h s2=%h want all 0", req_ready, rsp_valid, div_op, rsp_data, div_src1, div_src2);
    end
    tick();
    resetn = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, div_op} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_release: rdy=%b vld=%b op=%b want rdy=1 vld=0 op=0000", req_ready, rsp_valid, div_op);
    end
  endtask

  task automatic test_div_w;
    issue(4'b0001, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({div_op, req_ready, rsp_valid} !== 6'b000100 || div_src1 !== 32'hFFFF_FFF9 || div_src2 !== 32'd2) begin
        n_fail++; $display("FAIL div_w_busy[%0d]: op=%b rdy=%b vld=%b s1=%h s2=%h want op=0001 rdy=0 vld=0 s1=fffffff9 s2=2", i, div_op, req_ready, rsp_valid, div_src1, div_src2);
      end
      if (i == 3) div_done = 1'b1;
      tick();
    end
    div_done = 1'b0;
    n_checks++;
    if ({rsp_valid, div_op} !== 5'b10000 || rsp_data !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_w_result: vld=%b op=%b data=%h want vld=1 op=0000 data=fffffffd", rsp_valid, div_op, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL div_w_idle: rdy=%b vld=%b want rdy=1 vld=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_mod_wu_hold;
    issue(4'b1000, 32'd100, 32'd7);
    n_checks++;
    if (div_op !== 4'b1000) begin
      n_fail++; $display("FAIL mod_wu_op: got %b want 1000", div_op);
    end
    tick();
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd1; req_src2 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({rsp_valid, req_ready, div_op} !== 6'b100000 || rsp_data !== 32'd2) begin
        n_fail++; $display("FAIL mod_wu_hold[%0d]: vld=%b rdy=%b op=%b data=%h want vld=1 rdy=0 op=0000 data=2", i, rsp_valid, req_ready, div_op, rsp_data);
      end
      if (i == 1) div_done = 1'b1;
      tick();
      div_done = 1'b0;
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL mod_wu_handshake: vld=%b rdy=%b want vld=1 rdy=0", rsp_valid, req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL mod_wu_after: vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, req_ready);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_flush_drain;
    issue(4'b0010, 32'd50, 32'd5);
    tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL drain_flush_rdy: got %b want 0", req_ready);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      flush = (i == 0);
      #1;
      n_checks++;
      if ({div_op, rsp_valid, req_ready} !== 6'b001000) begin
        n_fail++; $display("FAIL drain_hold[%0d]: op=%b vld=%b rdy=%b want op=0010 vld=0 rdy=0", i, div_op, rsp_valid, req_ready);
      end
      tick();
    end
    flush = 1'b0;
    div_done = 1'b1;
    #1;
    n_checks++;
    if ({div_op, rsp_valid} !== 5'b00100) begin
      n_fail++; $display("FAIL drain_done_cycle: op=%b vld=%b want op=0010 vld=0", div_op, rsp_valid);
    end
    tick();
    div_done = 1'b0;
    #1;
    n_checks++;
    if ({div_op, rsp_valid, req_ready} !== 6'b000001) begin
      n_fail++; $display("FAIL drain_idle: op=%b vld=%b rdy=%b want op=0000 vld=0 rdy=1", div_op, rsp_valid, req_ready);
    end
  endtask

  task automatic test_flush_coincident;
    issue(4'b0001, 32'd9, 32'd3);
    flush = 1'b1; div_done = 1'b1;
    tick();
    flush = 1'b0; div_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({div_op, rsp_valid, req_ready} !== 6'b000001) begin
        n_fail++; $display("FAIL coincident_idle[%0d]: op=%b vld=%b rdy=%b want op=0000 vld=0 rdy=1", i, div_op, rsp_valid, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_flush_done;
    issue(4'b0100, 32'd17, 32'd5);
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd2) begin
      n_fail++; $display("FAIL flush_done_result: vld=%b data=%h want vld=1 data=2", rsp_valid, rsp_data);
    end
    flush = 1'b1; rsp_ready = 1'b1;
    tick();
    flush = 1'b0; rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_done_idle: vld=%b rdy=%b want vld=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_div_zero;
`ifdef DIV_ZERO_BYPASS_EN
    issue(4'b0010, 32'd123, 32'd0);
    n_checks++;
    if ({rsp_valid, div_op} !== 5'b10000 || rsp_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL bypass_div_wu: vld=%b op=%b data=%h want vld=1 op=0000 data=ffffffff", rsp_valid, div_op, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    issue(4'b0100, 32'd5, 32'd0);
    n_checks++;
    if ({rsp_valid, div_op} !== 5'b10000 || rsp_data !== 32'd5) begin
      n_fail++; $display("FAIL bypass_mod_w: vld=%b op=%b data=%h want vld=1 op=0000 data=5", rsp_valid, div_op, rsp_data);
    end
`else
    issue(4'b0010, 32'd123, 32'd0);
    n_checks++;
    if ({rsp_valid, div_op} !== 5'b00010) begin
      n_fail++; $display("FAIL zero_issue: vld=%b op=%b want vld=0 op=0010", rsp_valid, div_op);
    end
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL zero_passthru: vld=%b data=%h want vld=1 data=ffffffff", rsp_valid, rsp_data);
    end
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    issue(4'b0001, 32'd20, 32'hFFFF_FFFC);
    tick();
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, div_op} !== 6'b0 || rsp_data !== 32'd0 || {div_src1, div_src2} !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid_busy: rdy=%b vld=%b op=%b data=%h s1=%h s2=%h want all 0", req_ready, rsp_valid, div_op, rsp_data, div_src1, div_src2);
    end
    tick();
    resetn = 1'b1;
    issue(4'b0010, 32'd40, 32'd6);
    tick();
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd6) begin
      n_fail++; $display("FAIL reset_recover: vld=%b data=%h want vld=1 data=6", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = 4'b0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; rsp_ready = 1'b0; div_done = 1'b0;
    test_reset();
    test_div_w();
    test_mod_wu_hold();
    test_flush_drain();
    test_flush_coincident();
    test_flush_done();
    test_div_zero();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
